mem_stage_sram_ctrl: RTL and testbench
======================================

# mem_stage_sram_ctrl

Data-memory controller for the MEM stage of the ARM pipeline. It sits between the EX/MEM pipeline register (which supplies ALU result as address, Val_Rm as store data, and the MEM read/write enables) and the MEM/WB pipeline register (which consumes the loaded word). It converts each 32-bit load/store into two sequential 16-bit accesses on the external SRAM. It deasserts `ready` to freeze the whole pipeline until the access completes.

## Interface
- `BASE_ADDR`, 1024: byte address of data-memory word 0; subtracted before SRAM mapping.
- `ACCESS_CYCLES`, 2: cycles each 16-bit half-access is held on the SRAM bus (≥1).
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `wr_en` input 1: store request (from EX/MEM MEM_W_EN).
- `rd_en` input 1: load request (from EX/MEM MEM_R_EN).
- `address` input 32: byte address (ALU result).
- `write_data` input 32: store data (Val_Rm).
- `read_data` output 32: registered load result, to MEM/WB MEMdata.
- `ready` output 1: 1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- `sram_addr` output 18: SRAM halfword address.
- `sram_dq_out` output 16: write data to SRAM (top level builds tristate).
- `sram_dq_oe` output 1: 1 = drive `sram_dq_out` onto DQ.
- `sram_dq_in` input 16: read data from SRAM.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n` output 1 each: active-low strobes.
- `sram_ub_n`, `sram_lb_n` output 1 each: tied 0 (full halfword).

## Operation
- Word index w = ((address − BASE_ADDR) >> 2) mod 2^17; low half at `sram_addr` = {w,0}, high half at {w,1}. Out-of-range addresses wrap, no error.
- States: IDLE, LOW, HIGH, DONE. Cycle counter 0..ACCESS_CYCLES−1.
- IDLE: `ready` = ~(wr_en | rd_en). On request: latch w, write_data, op (wr_en has priority if both set), counter←0, go LOW.
- LOW: `sram_ce_n`=0, addr {w,0}. Write: `sram_we_n`=0, `sram_dq_oe`=1, `sram_dq_out`=data[15:0]. Read: `sram_oe_n`=0, on last counter cycle capture `sram_dq_in` into read_data[15:0]. After ACCESS_CYCLES cycles → HIGH, counter←0.
- HIGH: same as LOW with addr {w,1}, data bits [31:16]. After ACCESS_CYCLES cycles → DONE.
- DONE: all strobes inactive, `ready`=1 for exactly one cycle (pipeline advances on this edge); → IDLE unconditionally, so a still-visible request is not re-executed.
- Outside LOW/HIGH: `sram_we_n`=`sram_oe_n`=`sram_ce_n`=1, `sram_dq_oe`=0, `sram_addr` = 0.
- Latched values are used throughout; input changes mid-access are ignored.
- `read_data` changes only on read capture; held through stores and idle.

## Timing
- Reset: state IDLE, counter 0, `read_data`=0, `sram_dq_oe`=0, `sram_dq_out`=0, strobes 1, `sram_addr`=0, `ready`=1 (if no request).
- Request seen in cycle 0 (IDLE, ready=0); LOW cycles 1..A; HIGH A+1..2A; DONE 2A+1 (ready=1); A=ACCESS_CYCLES. Default: ready high in cycle 5, 5 freeze cycles.
- read_data[15:0] valid from cycle A+1, full word from cycle 2A+1 (sampled by MEM/WB at end of DONE).
- `sram_we_n` never low while `sram_oe_n` low; `sram_dq_oe`=1 only when `sram_we_n`=0.
- Reset mid-access: immediate return to IDLE, strobes released asynchronously, access aborted.
- Back-to-back requests: DONE→IDLE→LOW, one IDLE cycle between accesses (ready=0 in it).

## Test plan
- Reset with requests low -> ready=1, read_data=0, all strobes 1, sram_dq_oe=0.
- Store 0xDEADBEEF at 1024 -> SRAM addr 0 written 0xBEEF (cycles 1–2), addr 1 written 0xDEAD (cycles 3–4), ready=1 only in cycle 5.
- Load from 1024 with SRAM model -> read_data=0xDEADBEEF in cycle 5; oe_n low cycles 1–4, we_n stays 1.
- Store 0x12345678 at 1028 then immediate load 1028 -> sram_addr 2/3, load returns 0x12345678; one ready=0 IDLE cycle between ops.
- wr_en=rd_en=1 -> treated as store; read_data unchanged.
- rst pulse in cycle 3 of a store -> strobes release asynchronously, IDLE next, addr 1 not written; address 1024+4·2^17 -> sram_addr 0/1 (wrap).

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// sequential 16-bit SRAM accesses (low half, then high half) and holds the
// pipeline frozen via `ready` until the word access has completed.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  // Counter must be at least one bit wide even when each half takes one cycle.
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [16:0]     word_reg;
  logic [31:0]     data_reg;
  logic            op_wr_reg;

  logic [31:0]     offset;
  logic [16:0]     word_in;
  logic            req;
  logic            unused_offset_bits;

  // Word index relative to the data-memory base; upper bits drop, so
  // out-of-range addresses simply wrap around the SRAM.
  assign offset             = address - 32'(BASE_ADDR);
  assign word_in            = offset[18:2];
  assign unused_offset_bits = &{1'b0, offset[31:19], offset[1:0]};
  assign req                = wr_en | rd_en;

  // Byte lanes are always both enabled: every access is a full halfword.
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  // Freeze while a request is pending; release for exactly the DONE cycle.
  assign ready = (state_reg == IDLE) ? ~req : (state_reg == DONE);

  // Access sequencer; SRAM strobes are registered and set up on the edge
  // entering each phase so they are clean for the whole phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      word_reg    <= '0;
      data_reg    <= '0;
      op_wr_reg   <= 1'b0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_ce_n   <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            // Store wins when both enables are set.
            word_reg    <= word_in;
            data_reg    <= write_data;
            op_wr_reg   <= wr_en;
            cnt_reg     <= '0;
            state_reg   <= LOW;
            sram_ce_n   <= 1'b0;
            sram_addr   <= {word_in, 1'b0};
            sram_we_n   <= ~wr_en;
            sram_oe_n   <= wr_en;
            sram_dq_oe  <= wr_en;
            sram_dq_out <= wr_en ? write_data[15:0] : 16'h0000;
          end
        end
        LOW: begin
          if (cnt_reg == LAST) begin
            if (!op_wr_reg) begin
              read_data[15:0] <= sram_dq_in;
            end
            cnt_reg     <= '0;
            state_reg   <= HIGH;
            sram_addr   <= {word_reg, 1'b1};
            sram_dq_out <= op_wr_reg ? data_reg[31:16] : 16'h0000;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HIGH: begin
          if (cnt_reg == LAST) begin
            if (!op_wr_reg) begin
              read_data[31:16] <= sram_dq_in;
            end
            cnt_reg     <= '0;
            state_reg   <= DONE;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_ce_n   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // Pipeline advances on this edge; never re-issue the same request.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: directed cases plus randomized
// loads/stores checked against a word-level reference memory.
module tb_mem_stage_sram_ctrl;

  localparam int A    = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  mem_stage_sram_ctrl #(.BASE_ADDR(BASE), .ACCESS_CYCLES(A)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // External SRAM: asynchronous read, write committed on the clock edge.
  logic [15:0] sram_mem [0:262143];
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;

  // Reference: word-addressed memory and the expected read_data register.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return int'((off / 4) % 131072);
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  // Runs one access starting in an IDLE cycle; returns in the DONE cycle.
  task automatic do_op(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data);
    int          w;
    logic        is_wr;
    logic        hi;
    logic [31:0] ld;
    w     = word_of(addr);
    is_wr = wr;
    ld    = ref_word(w);
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    #1 check_eq("ready_c0", {31'b0, ready}, 32'd0);
    for (int k = 1; k <= 2 * A; k++) begin
      hi = (k > A);
      @(posedge clk); #1;
      if (k == 1) begin
        // Inputs changing mid-access must have no effect.
        address    = $urandom;
        write_data = $urandom;
      end
      check_eq("ready_busy", {31'b0, ready}, 32'd0);
      check_eq("sram_addr", {14'b0, sram_addr}, {14'b0, 17'(w), hi});
      check_eq("strobes", {28'b0, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe},
               {28'b0, 1'b0, ~is_wr, is_wr, is_wr});
      if (is_wr)
        check_eq("dq_out", {16'b0, sram_dq_out}, {16'b0, hi ? data[31:16] : data[15:0]});
      if (!is_wr && k == A + 1)
        check_eq("rd_low", {16'b0, read_data[15:0]}, {16'b0, ld[15:0]});
    end
    @(posedge clk); #1;
    if (is_wr) ref_mem[w] = data;
    else exp_rd = ld;
    check_eq("ready_done", {31'b0, ready}, 32'd1);
    check_eq("strobes_done", {10'b0, sram_addr, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe},
             {10'b0, 18'd0, 4'b1110});
    check_eq("read_data", read_data, exp_rd);
    $display("op %s addr=0x%08h word=%0d data=0x%08h read_data=0x%08h",
             is_wr ? "ST" : "LD", addr, w, data, read_data);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    next_cycle();
    check_eq("ready_idle", {31'b0, ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [15:0] old_hi;
    int          kind;
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    exp_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'b0, ready}, 32'd1);
    check_eq("rst_read_data", read_data, 32'h0);
    check_eq("rst_strobes", {10'b0, sram_addr, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe},
             {10'b0, 18'd0, 4'b1110});
    check_eq("rst_dq_out", {16'b0, sram_dq_out}, 32'h0);
    rst = 1'b0;
    idle_cycle();

    // Directed: store, load, back-to-back, both-enables, wrap.
    next_cycle(); do_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    check_eq("sram0", {16'b0, sram_mem[0]}, 32'h0000BEEF);
    check_eq("sram1", {16'b0, sram_mem[1]}, 32'h0000DEAD);
    next_cycle(); do_op(1'b0, 1'b1, 32'd1024, 32'h0);
    next_cycle(); do_op(1'b1, 1'b0, 32'd1028, 32'h12345678);
    next_cycle(); do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    check_eq("sram2", {16'b0, sram_mem[2]}, 32'h00005678);
    check_eq("sram3", {16'b0, sram_mem[3]}, 32'h00001234);
    next_cycle(); do_op(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A);
    next_cycle(); do_op(1'b1, 1'b0, 32'd1024 + 4 * 131072, 32'h0BADF00D);
    check_eq("wrap_sram0", {16'b0, sram_mem[0]}, 32'h0000F00D);
    next_cycle(); do_op(1'b0, 1'b1, 32'd1024, 32'h0);

    // Randomized mix of loads, stores and dual-enable requests with gaps.
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      kind = $urandom_range(0, 2);
      a = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = a + 32'(4 * 131072);
      d = $urandom;
      next_cycle();
      do_op(kind != 1, kind != 0, a, d);
    end

    // Reset in cycle 3 of a store aborts it before the high half is written.
    old_hi = ref_word(0) >> 16;
    next_cycle();
    wr_en = 1'b1; address = 32'd1024; write_data = 32'hCAFEF00D;
    repeat (3) next_cycle();
    check_eq("pre_rst_we", {31'b0, sram_we_n}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check_eq("async_release", {10'b0, sram_addr, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe},
             {10'b0, 18'd0, 4'b1110});
    check_eq("rst_clears_rd", read_data, 32'h0);
    wr_en = 1'b0;
    #1 rst = 1'b0;
    exp_rd = '0;
    ref_mem[0] = {old_hi, 16'hF00D};
    idle_cycle();
    check_eq("abort_sram1", {16'b0, sram_mem[1]}, {16'b0, old_hi});
    check_eq("abort_sram0", {16'b0, sram_mem[0]}, 32'h0000F00D);
    next_cycle(); do_op(1'b0, 1'b1, 32'd1024, 32'h0);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
